dm_cache: RTL and testbench

//  Parametrised direct-mapped, write-through, write-allocate cache; one word per line.

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_line_store.sv | 43 ++++
 rtl/dm_cache.sv | 143 ++++++++++++++
 tb/tb_dm_cache.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } cache_state_t;

  // Tag bits left after removing the index and the byte-in-word offset.
  function automatic int tag_w(input int addr_w, input int depth);
    return addr_w - depth - 2;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Per-line tag/data/valid storage: combinational read, one write port, bulk valid clear.
module cache_line_store #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int TAG_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [DEPTH-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             inv
);
  localparam int LINES = 2**DEPTH;

  logic [LINES-1:0]            valid;
  logic [LINES-1:0][TAG_W-1:0] tags;
  logic [LINES-1:0][WIDTH-1:0] data;

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

  // Only valid bits are reset; a cleared valid bit masks stale tag/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     valid         <= '0;
    else if (inv)   valid         <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-through/write-allocate cache with req/ack memory handshake.
// Optional hit/miss counters are enabled with CACHE_STATS_EN.
module dm_cache
  import cache_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WIDTH-1:0]  cpu_wdata,
  output logic [WIDTH-1:0]  cpu_rdata,
  output logic              cpu_ready,
  input  logic              cpu_inv,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
`ifdef CACHE_STATS_EN
  input  logic              mem_ack,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`else
  input  logic              mem_ack
`endif
);
  localparam int TAG_W = tag_w(ADDR_W, DEPTH);

  cache_state_t state, state_nxt;

  logic [DEPTH-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [WIDTH-1:0] line_data;
  logic             hit;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             inv_now;
  logic             rd_hit_evt;
  logic             miss_evt;

  assign idx     = cpu_addr[DEPTH+1:2];
  assign tag     = cpu_addr[ADDR_W-1:DEPTH+2];
  assign hit     = line_valid && (line_tag == tag);
  assign inv_now = (state == IDLE) && cpu_inv;

  // Refill installs memory data; a write installs the CPU data (write-allocate).
  assign wr_en   = ((state == REFILL) || (state == WRITE)) && mem_ack;
  assign wr_data = (state == WRITE) ? cpu_wdata : mem_rdata;

  assign rd_hit_evt = (state == IDLE) && !cpu_inv && cpu_req && !cpu_we && hit;
  assign miss_evt   = (state == IDLE) && !cpu_inv && cpu_req && !cpu_we && !hit;

  cache_line_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (wr_data),
    .inv      (inv_now)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!cpu_inv && cpu_req) begin
          if (cpu_we)    state_nxt = WRITE;
          else if (!hit) state_nxt = REFILL;
        end
      end
      REFILL, WRITE: if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address is masked rather than sliced so the ignored byte bits stay word-aligned.
  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (rd_hit_evt) begin
          cpu_ready = 1'b1;
          cpu_rdata = line_data;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = cpu_addr & ~ADDR_W'(3);
        if (mem_ack) begin
          cpu_ready = 1'b1;
          cpu_rdata = mem_rdata;
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cpu_addr & ~ADDR_W'(3);
        mem_wdata = cpu_wdata;
        cpu_ready = mem_ack;
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (rd_hit_evt && (hit_cnt  != 32'hFFFF_FFFF)) hit_cnt  <= hit_cnt + 32'd1;
      if (miss_evt   && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache.sv
// Scoreboard bench for dm_cache: expected completions queued at issue, popped at cpu_ready.
module tb_dm_cache;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_inv, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  typedef struct {
    logic [31:0] rdata;
    bit          we;
    int          cycles;
    int          reqc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dm_cache #(.WIDTH(32), .DEPTH(3), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_inv   (cpu_inv),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
`ifdef CACHE_STATS_EN
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`else
    .mem_ack   (mem_ack)
`endif
  );

  task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tg, got, exp);
    end
  endtask

  // One CPU access; memory acks on the lat-th cycle of mem_req.
  task automatic access(input string tg, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] memdata,
                        input int lat, input bit inv_first,
                        input logic [31:0] exp_rdata, input int exp_cycles, input int exp_reqc);
    exp_t e;
    int   cyc = 0;
    int   reqc = 0;
    bit   done = 0;
    sb.push_back('{rdata: exp_rdata, we: we, cycles: exp_cycles, reqc: exp_reqc});
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_inv = inv_first;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        reqc++;
        if (reqc == 1) begin
          chk({tg, " mem_we"}, 64'(mem_we), 64'(we));
          chk({tg, " mem_addr"}, 64'(mem_addr), 64'(addr & 32'hFFFF_FFFC));
          if (we) chk({tg, " mem_wdata"}, 64'(mem_wdata), 64'(wdata));
        end
        if (reqc == lat) begin
          mem_ack = 1'b1; mem_rdata = memdata;
        end
      end
      #1;
      if (cpu_inv) chk({tg, " inv_ready"}, 64'(cpu_ready), 64'(0));
      if (cpu_ready) begin
        done = 1;
        e = sb.pop_front();
        chk({tg, " cycles"}, 64'(cyc), 64'(e.cycles));
        chk({tg, " req_cycles"}, 64'(reqc), 64'(e.reqc));
        if (!e.we) chk({tg, " rdata"}, 64'(cpu_rdata), 64'(e.rdata));
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; cpu_inv = 1'b0;
      if (done) cpu_req = 1'b0;
    end
    if (!done) begin
      chk({tg, " timeout"}, 64'(0), 64'(1));
      void'(sb.pop_front());
      cpu_req = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_inv = 0; cpu_addr = 0; cpu_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    #12;
    chk("rst mem_req", 64'(mem_req), 64'(0));
    chk("rst cpu_ready", 64'(cpu_ready), 64'(0));
    chk("rst mem_addr", 64'(mem_addr), 64'(0));
`ifdef CACHE_STATS_EN
    chk("rst hit_cnt", 64'(hit_cnt), 64'(0));
    chk("rst miss_cnt", 64'(miss_cnt), 64'(0));
`endif
    @(posedge clk); #1 rst_n = 1'b1;

    access("t1 miss",     0, 32'h100, 0, 32'hDEADBEEF, 3, 0, 32'hDEADBEEF, 4, 3);
    access("t2 hit",      0, 32'h100, 0, 32'h0,        1, 0, 32'hDEADBEEF, 1, 0);
`ifdef CACHE_STATS_EN
    chk("t2 hit_cnt", 64'(hit_cnt), 64'(1));
    chk("t2 miss_cnt", 64'(miss_cnt), 64'(1));
`endif
    access("t3 conflict", 0, 32'h120, 0, 32'hCAFEF00D, 2, 0, 32'hCAFEF00D, 3, 2);
    access("t3 evicted",  0, 32'h100, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 2, 1);
    access("t4 write",    1, 32'h104, 32'h12345678, 0, 1, 0, 32'h0, 2, 1);
    access("t4 rd hit",   0, 32'h107, 0, 32'h0,        1, 0, 32'h12345678, 1, 0);
    access("t5 inv",      0, 32'h104, 0, 32'hAAAA5555, 2, 1, 32'hAAAA5555, 4, 2);
    access("t5 inv miss", 0, 32'h100, 0, 32'h11112222, 1, 0, 32'h11112222, 2, 1);
    access("wr alloc",    1, 32'h13C, 32'h0BADCAFE, 0, 3, 0, 32'h0, 4, 3);
    access("wr alloc hit",0, 32'h13C, 0, 32'h0,        1, 0, 32'h0BADCAFE, 1, 0);

    // Stray ack in IDLE must not complete anything.
    @(posedge clk); #1 mem_ack = 1'b1;
    @(negedge clk);
    chk("idle ack ready", 64'(cpu_ready), 64'(0));
    chk("idle ack req", 64'(mem_req), 64'(0));
    @(posedge clk); #1 mem_ack = 1'b0;

    // Reset in the second REFILL cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h108;
    @(negedge clk);
    chk("t6 idle req", 64'(mem_req), 64'(0));
    @(negedge clk);
    chk("t6 refill1 req", 64'(mem_req), 64'(1));
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t6 async req", 64'(mem_req), 64'(0));
    chk("t6 async ready", 64'(cpu_ready), 64'(0));
    cpu_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    chk("t6 late ack ready", 64'(cpu_ready), 64'(0));
    chk("t6 late ack req", 64'(mem_req), 64'(0));
    @(posedge clk); #1 mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
    chk("t6 hit_cnt", 64'(hit_cnt), 64'(0));
    chk("t6 miss_cnt", 64'(miss_cnt), 64'(0));
`endif
    access("t6 post miss", 0, 32'h100, 0, 32'h33334444, 1, 0, 32'h33334444, 2, 1);
    access("t6 no update", 0, 32'h108, 0, 32'h66667777, 1, 0, 32'h66667777, 2, 1);
    access("t6 post hit",  0, 32'h100, 0, 32'h0,        1, 0, 32'h33334444, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
